// File: rtl/regfile_bypass_pkg.sv
// Shared types and sizes for the register file and the pipeline flops that carry register selects.
package regfile_bypass_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned SEL_W    = 3;

    localparam logic [DATA_W-1:0] RESET_VAL = 16'h0000;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [SEL_W-1:0]  reg_sel_t;

    // Architectural register encoding, shared with the ID..MEM_WB select pipeline.
    typedef enum logic [SEL_W-1:0] {
        R0 = 3'd0,
        R1 = 3'd1,
        R2 = 3'd2,
        R3 = 3'd3,
        R4 = 3'd4,
        R5 = 3'd5,
        R6 = 3'd6,
        R7 = 3'd7
    } reg_sel_e;

endpackage

// File: rtl/regfile_bypass_if.sv
// Writeback/decode side bus of the register file: one write port, two read ports, error flag.
interface regfile_bypass_if;
    import regfile_bypass_pkg::*;

    logic     RegWrt;
    reg_sel_t writeRegSel;
    data_t    writeData;
    reg_sel_t read1RegSel;
    reg_sel_t read2RegSel;
    data_t    read1Data;
    data_t    read2Data;
    logic     err;

    modport master (
        output RegWrt, writeRegSel, writeData, read1RegSel, read2RegSel,
        input  read1Data, read2Data, err
    );

    modport slave (
        input  RegWrt, writeRegSel, writeData, read1RegSel, read2RegSel,
        output read1Data, read2Data, err
    );

endinterface

// File: rtl/regfile_bypass_reg16.sv
// One architectural register: DATA_W dff bits with shared write enable and synchronous reset.
module regfile_bypass_reg16
    import regfile_bypass_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  data_t d,
    output data_t q
);

    // Storage flops; reset wins over a simultaneous write.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile_bypass.sv
// Architectural register file fed by the writeback stage, read asynchronously by decode.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_bypass
    import regfile_bypass_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    regfile_bypass_if.slave rf
);

    logic [NUM_REGS-1:0] wr_en;
    data_t               regs [NUM_REGS];
    data_t               stored1;
    data_t               stored2;

    // Write decoder: at most one register enabled per cycle.
    always_comb begin
        wr_en = '0;
        if (rf.RegWrt) begin
            wr_en[rf.writeRegSel] = 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
        regfile_bypass_reg16 u_reg (
            .clk (clk),
            .rst (rst),
            .en  (wr_en[g]),
            .d   (rf.writeData),
            .q   (regs[g])
        );
    end

    // Read muxes over stored contents.
    always_comb begin
        stored1 = regs[rf.read1RegSel];
        stored2 = regs[rf.read2RegSel];
    end

`ifdef REGFILE_BYPASS_EN
    // Bypass each read port independently when it targets the register being written; never during reset.
    always_comb begin
        rf.read1Data = stored1;
        rf.read2Data = stored2;
        if (!rst && rf.RegWrt && (rf.writeRegSel == rf.read1RegSel)) begin
            rf.read1Data = rf.writeData;
        end
        if (!rst && rf.RegWrt && (rf.writeRegSel == rf.read2RegSel)) begin
            rf.read2Data = rf.writeData;
        end
    end
`else
    // No bypass: a write becomes visible the cycle after its edge.
    always_comb begin
        rf.read1Data = stored1;
        rf.read2Data = stored2;
    end
`endif

    // Flag unknown control/select inputs; an X/Z anywhere poisons the reduction XOR.
    always_comb begin
        rf.err = ((^{rf.RegWrt, rf.writeRegSel, rf.read1RegSel, rf.read2RegSel}) === 1'bx);
    end

endmodule

// File: tb/tb_regfile_bypass.sv
// Directed scoreboard bench for regfile_bypass; expectations adapt to REGFILE_BYPASS_EN.
module tb_regfile_bypass;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst;

    regfile_bypass_if bus ();

    regfile_bypass dut (
        .clk (clk),
        .rst (rst),
        .rf  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] exp_q [$];
    string       tag_q [$];
    int          pass_cnt  = 0;
    int          fail_cnt  = 0;
    int          total_cnt = 0;

    function automatic void chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endfunction

    // Drive one cycle of stimulus, push expected reads, compare at the falling edge, then advance past the rising edge.
    task automatic step(input string tag, input logic r, input logic we,
                        input logic [2:0] ws, input logic [15:0] wd,
                        input logic [2:0] s1, input logic [2:0] s2,
                        input logic [15:0] e1, input logic [15:0] e2);
        string t;
        logic [15:0] x1;
        logic [15:0] x2;
        rst             = r;
        bus.RegWrt      = we;
        bus.writeRegSel = ws;
        bus.writeData   = wd;
        bus.read1RegSel = s1;
        bus.read2RegSel = s2;
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        tag_q.push_back(tag);
        @(negedge clk);
        t  = tag_q.pop_front();
        x1 = exp_q.pop_front();
        x2 = exp_q.pop_front();
        chk({t, "_rd1"}, bus.read1Data, x1);
        chk({t, "_rd2"}, bus.read2Data, x2);
        chk({t, "_err"}, 16'(bus.err), 16'h0000);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst             = 1'b1;
        bus.RegWrt      = 1'b1;
        bus.writeRegSel = 3'd3;
        bus.writeData   = 16'hBEEF;
        bus.read1RegSel = 3'd3;
        bus.read2RegSel = 3'd3;
        @(posedge clk);
        #1;

        // Second reset cycle: registers already cleared, write of R3 must not land or bypass.
        step("rst_hold", 1'b1, 1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd3, 16'h0000, 16'h0000);

        for (int i = 0; i < 8; i++) begin
            step($sformatf("rst_r%0d", i), 1'b0, 1'b0, 3'd0, 16'h0000, 3'(i), 3'(7 - i), 16'h0000, 16'h0000);
        end

        // Write/readback, plus a write to R7 that must not disturb a read of R1.
        step("wr_r1", 1'b0, 1'b1, 3'd1, 16'h1234, 3'd0, 3'd0, 16'h0000, 16'h0000);
        step("wr_r7", 1'b0, 1'b1, 3'd7, 16'hFFFF, 3'd1, 3'd0, 16'h1234, 16'h0000);
        step("rb_1_7", 1'b0, 1'b0, 3'd0, 16'h0000, 3'd1, 3'd7, 16'h1234, 16'hFFFF);
        for (int i = 0; i < 7; i++) begin
            if (i != 1) begin
                step($sformatf("rb_zero_r%0d", i), 1'b0, 1'b0, 3'd0, 16'h0000, 3'(i), 3'(i), 16'h0000, 16'h0000);
            end
        end

        // Same-cycle write/read hazard on R2.
        step("r2_init", 1'b0, 1'b1, 3'd2, 16'h00AA, 3'd1, 3'd7, 16'h1234, 16'hFFFF);
        step("haz_r2", 1'b0, 1'b1, 3'd2, 16'h5555, 3'd2, 3'd2,
             BYP ? 16'h5555 : 16'h00AA, BYP ? 16'h5555 : 16'h00AA);
        step("haz_after", 1'b0, 1'b0, 3'd2, 16'h5555, 3'd2, 3'd2, 16'h5555, 16'h5555);

        // Write disabled: R4 untouched, no bypass.
        for (int i = 0; i < 3; i++) begin
            step($sformatf("wdis_%0d", i), 1'b0, 1'b0, 3'd4, 16'hDEAD, 3'd4, 3'd4, 16'h0000, 16'h0000);
        end
        step("wdis_after", 1'b0, 1'b0, 3'd0, 16'h0000, 3'd4, 3'd2, 16'h0000, 16'h5555);

        // Back-to-back writes to R5.
        step("b2b_1", 1'b0, 1'b1, 3'd5, 16'h0001, 3'd5, 3'd5,
             BYP ? 16'h0001 : 16'h0000, BYP ? 16'h0001 : 16'h0000);
        step("b2b_2", 1'b0, 1'b1, 3'd5, 16'h0002, 3'd5, 3'd5,
             BYP ? 16'h0002 : 16'h0001, BYP ? 16'h0002 : 16'h0001);
        step("b2b_3", 1'b0, 1'b1, 3'd5, 16'h0003, 3'd5, 3'd5,
             BYP ? 16'h0003 : 16'h0002, BYP ? 16'h0003 : 16'h0002);
        step("b2b_final", 1'b0, 1'b0, 3'd0, 16'h0000, 3'd5, 3'd5, 16'h0003, 16'h0003);

        // Reset mid-operation discards the pending write and suppresses bypass.
        step("r6_init", 1'b0, 1'b1, 3'd6, 16'h7777, 3'd5, 3'd1, 16'h0003, 16'h1234);
        step("r6_rst", 1'b1, 1'b1, 3'd6, 16'h8888, 3'd6, 3'd6, 16'h7777, 16'h7777);
        step("r6_post", 1'b0, 1'b0, 3'd0, 16'h0000, 3'd6, 3'd1, 16'h0000, 16'h0000);
        step("post_rst_5_7", 1'b0, 1'b0, 3'd0, 16'h0000, 3'd5, 3'd7, 16'h0000, 16'h0000);

        // R0 is a normal writable register.
        step("wr_r0", 1'b0, 1'b1, 3'd0, 16'hA5A5, 3'd0, 3'd1,
             BYP ? 16'hA5A5 : 16'h0000, 16'h0000);
        step("rb_r0", 1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 16'hA5A5, 16'hA5A5);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
